// File: rtl/fifo_wr_arbiter.sv
// Multi-requester write arbiter in front of a single FIFO write port, with bounded bursts per grant.
// Define FIFO_ARB_FIXED_PRIO_EN for fixed-priority selection (lowest index wins); round-robin otherwise.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          wr,
    output logic [DATA_WIDTH-1:0]         w_data
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [CW-1:0]        burstCnt_q, burstCnt_d;

    logic [NUM_REQ-1:0]   winnerOh;
    logic [PW-1:0]        winnerIdx;
    logic                 winnerValid;
    logic                 ownerReq;
    logic                 burstDone;
    logic                 grantEnds;
    logic                 takeGrant;

`ifndef FIFO_ARB_FIXED_PRIO_EN
    logic [PW-1:0]        rrPtr_q, rrPtr_d;
`endif

    // Winner search over the raw req vector; in round-robin mode the current owner sits
    // last in the search order, so it is only re-selected when nobody else is asking.
    always_comb begin : selectWinner
        int idx;
        idx         = 0;
        winnerOh    = '0;
        winnerIdx   = '0;
        winnerValid = 1'b0;
`ifdef FIFO_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winnerValid = 1'b1;
                winnerIdx   = PW'(i);
            end
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rrPtr_q) + k) % NUM_REQ;
            if (req[PW'(idx)]) begin
                winnerValid = 1'b1;
                winnerIdx   = PW'(idx);
            end
        end
`endif
        if (winnerValid) begin
            winnerOh[winnerIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            burstCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            burstCnt_q <= burstCnt_d;
        end
    end

    always_comb begin
        ownerReq   = |(gnt_q & req);
        burstDone  = wr && (burstCnt_q == CW'(MAX_BURST - 1));
        grantEnds  = !ownerReq || burstDone;
        takeGrant  = 1'b0;
        state_d    = state_q;
        gnt_d      = gnt_q;
        burstCnt_d = burstCnt_q;
        case (state_q)
            IDLE: begin
                if (winnerValid) begin
                    takeGrant  = 1'b1;
                    state_d    = BUSY;
                    gnt_d      = winnerOh;
                    burstCnt_d = '0;
                end
            end
            BUSY: begin
                if (grantEnds) begin
                    burstCnt_d = '0;
                    if (winnerValid) begin
                        takeGrant = 1'b1;
                        gnt_d     = winnerOh;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (wr) begin
                    burstCnt_d = burstCnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                burstCnt_d = '0;
            end
        endcase
    end

`ifndef FIFO_ARB_FIXED_PRIO_EN
    always_comb begin
        rrPtr_d = rrPtr_q;
        if (takeGrant) begin
            rrPtr_d = (winnerIdx == PW'(NUM_REQ - 1)) ? '0 : winnerIdx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rrPtr_q <= '0;
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end
`endif

    // Full stalls the owner in place: no ack, so the burst count and grant simply hold.
    always_comb begin
        gnt    = gnt_q;
        ack    = gnt_q & req & {NUM_REQ{~full}};
        wr     = |ack;
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                w_data = w_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
